// File: rtl/mesh_seq_pkg.sv
// Shared types and helpers for the mesh job sequencer: FSM state encoding,
// default mesh geometry and the {row, col} preload address packing.
package mesh_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        START = 3'd3,
        RUN   = 3'd4,
        DONE  = 3'd5
    } seq_state_e;

    localparam int MESH_ROWS = 16;
    localparam int MESH_COLS = 4;
    localparam int NUM_W     = MESH_ROWS * MESH_COLS;

    // Weights arrive row-major; the mesh preload port wants {row, col}.
    function automatic int pack_addr(input int idx, input int cols, input int col_w);
        return ((idx / cols) << col_w) | (idx % cols);
    endfunction

endpackage

// File: rtl/mesh_job_sequencer.sv
// Job-level controller for the systolic mesh: streams weights into the mesh
// preload port, pulses start, waits the compute window and hands back the result.
module mesh_job_sequencer
    import mesh_seq_pkg::*;
#(
    parameter int DW             = 8,
    parameter int ROWS           = MESH_ROWS,
    parameter int COLS           = MESH_COLS,
    parameter int ROW_W          = 4,
    parameter int COL_W          = 2,
    parameter int ACC_W          = 16,
    parameter int COMPUTE_CYCLES = 20,
    parameter int CNT_W          = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic                     job_skip_load,
    input  logic [COLS*DW-1:0]       job_x_flat,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [DW-1:0]            w_data,
    output logic                     preload_valid,
    output logic [ROW_W+COL_W-1:0]   preload_addr,
    output logic [DW-1:0]            preload_data,
    output logic                     start,
    output logic [COLS*DW-1:0]       x_vector_flat,
    input  logic [ROWS*ACC_W-1:0]    mesh_result_flat,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ROWS*ACC_W-1:0]    res_data,
    output logic                     busy
);

    localparam int ADDR_W  = ROW_W + COL_W;
    localparam int NUM_WTS = ROWS * COLS;

    localparam logic [CNT_W-1:0] LAST_W   = CNT_W'(NUM_WTS - 1);
    localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(COMPUTE_CYCLES - 1);

    seq_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       loaded_q, loaded_d;
    logic [COLS*DW-1:0]         x_q, x_d;
    logic                       pv_q, pv_d;
    logic [ADDR_W-1:0]          paddr_q, paddr_d;
    logic [DW-1:0]              pdata_q, pdata_d;
    logic [ROWS*ACC_W-1:0]      res_q, res_d;

    // Handshake readies depend on state only; job_ready is also held low in reset.
    assign job_ready     = (state_q == IDLE) && !rst;
    assign w_ready       = (state_q == LOAD);
    assign start         = (state_q == START);
    assign res_valid     = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign preload_valid = pv_q;
    assign preload_addr  = paddr_q;
    assign preload_data  = pdata_q;
    assign x_vector_flat = x_q;
    assign res_data      = res_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        x_d      = x_q;
        pv_d     = 1'b0;
        paddr_d  = paddr_q;
        pdata_d  = pdata_q;
        res_d    = res_q;

        unique case (state_q)
            IDLE: begin
                if (job_valid && job_ready) begin
                    x_d   = job_x_flat;
                    cnt_d = '0;
                    if (job_skip_load && loaded_q) begin
                        state_d = START;
                    end else begin
                        // Resident weights are being overwritten from here on.
                        loaded_d = 1'b0;
                        state_d  = LOAD;
                    end
                end
            end

            LOAD: begin
                if (w_valid) begin
                    pv_d    = 1'b1;
                    paddr_d = ADDR_W'(pack_addr(32'(cnt_q), COLS, COL_W));
                    pdata_d = w_data;
                    if (cnt_q == LAST_W) begin
                        cnt_d   = '0;
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            FLUSH: begin
                loaded_d = 1'b1;
                state_d  = START;
            end

            START: begin
                cnt_d   = '0;
                state_d = RUN;
            end

            RUN: begin
                if (cnt_q == LAST_RUN) begin
                    res_d   = mesh_result_flat;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
            x_q      <= '0;
            pv_q     <= 1'b0;
            paddr_q  <= '0;
            pdata_q  <= '0;
            res_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            x_q      <= x_d;
            pv_q     <= pv_d;
            paddr_q  <= paddr_d;
            pdata_q  <= pdata_d;
            res_q    <= res_d;
        end
    end

    a_start_single: assert property (@(posedge clk) disable iff (rst)
        start |=> !start);

    a_preload_follows_hs: assert property (@(posedge clk) disable iff (rst)
        (w_valid && w_ready) |=> preload_valid);

    a_res_stable: assert property (@(posedge clk) disable iff (rst)
        (res_valid && !res_ready) |=> (res_valid && $stable(res_data)));

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        (state_q == LOAD) |-> (cnt_q <= LAST_W));

endmodule
